// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: EX->MEM pipeline boundary placed directly after the ALU.
// Holds the ALU result, store data, branch target, destination register and
// MEM/WB controls. BEQ/BNE are resolved here from the ALU zero flag.
// Valid/ready handshake on both sides, with a 2-entry skid buffer (OUT + SKID)
// so that a MEM-side stall never drops an instruction. o_ready is a registered
// state decode, so there is no combinational path from i_ready to o_ready.
// Optional feature macro: OVF_TRAP_EN (overflow trap). Without it, i_ovf is
// ignored and o_exception is tied low.
module ex_mem_stage_reg #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_flush,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_alu_zero,
    input  logic [NB_DATA-1:0] i_store_data,
    input  logic [NB_DATA-1:0] i_branch_target,
    input  logic [NB_REG-1:0]  i_rd_addr,
    input  logic [4:0]         i_ctrl,
    input  logic               i_ovf,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_alu_result,
    output logic [NB_DATA-1:0] o_store_data,
    output logic [NB_DATA-1:0] o_branch_target,
    output logic [NB_REG-1:0]  o_rd_addr,
    output logic               o_reg_write,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_branch_taken,
    output logic               o_exception
);

    // Payload layout: {alu, store, target, rd, reg_write, mem_read, mem_write, taken, exception}
    localparam int PW = 3 * NB_DATA + NB_REG + 5;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Branch decision: BEQ taken on zero, BNE taken on non-zero.
    function automatic logic resolve_branch(input logic beq, input logic bne, input logic zero);
        return (beq & zero) | (bne & ~zero);
    endfunction

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [PW-1:0] out_r;
    logic [PW-1:0] out_nxt_s;
    logic [PW-1:0] skid_r;
    logic [PW-1:0] skid_nxt_s;
    logic          ready_r;
    logic          valid_r;
    logic          in_fire_s;
    logic          out_fire_s;
    logic          cap_reg_write_s;
    logic          cap_mem_read_s;
    logic          cap_mem_write_s;
    logic          cap_taken_s;
    logic          cap_exc_s;
    logic [PW-1:0] cap_s;
    logic          unused_ovf_s;

    assign in_fire_s    = i_valid & ready_r;
    assign out_fire_s   = valid_r & i_ready;
    assign unused_ovf_s = i_ovf;

    // Build the payload captured from EX, including branch resolution and overflow trap.
    always_comb begin
        cap_reg_write_s = i_ctrl[4];
        cap_mem_read_s  = i_ctrl[3];
        cap_mem_write_s = i_ctrl[2];
        cap_taken_s     = resolve_branch(i_ctrl[1], i_ctrl[0], i_alu_zero);
        cap_exc_s       = 1'b0;
`ifdef OVF_TRAP_EN
        if (i_ovf) begin
            cap_reg_write_s = 1'b0;
            cap_mem_read_s  = 1'b0;
            cap_mem_write_s = 1'b0;
            cap_taken_s     = 1'b0;
            cap_exc_s       = 1'b1;
        end else begin
            cap_exc_s       = 1'b0;
        end
`endif
        cap_s = {i_alu_result, i_store_data, i_branch_target, i_rd_addr,
                 cap_reg_write_s, cap_mem_read_s, cap_mem_write_s, cap_taken_s, cap_exc_s};
    end

    // Skid-buffer state machine; leaving OUT empty always clears its control bits.
    always_comb begin
        state_nxt_s = state_r;
        out_nxt_s   = out_r;
        skid_nxt_s  = skid_r;
        if (i_flush) begin
            state_nxt_s = ST_EMPTY;
            out_nxt_s   = {out_r[PW-1:5], 5'b00000};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        out_nxt_s   = cap_s;
                        state_nxt_s = ST_BUSY;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire_s && out_fire_s) begin
                        out_nxt_s   = cap_s;
                    end else if (in_fire_s) begin
                        skid_nxt_s  = cap_s;
                        state_nxt_s = ST_FULL;
                    end else if (out_fire_s) begin
                        out_nxt_s   = {out_r[PW-1:5], 5'b00000};
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        out_nxt_s   = skid_r;
                        state_nxt_s = ST_BUSY;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                    out_nxt_s   = {out_r[PW-1:5], 5'b00000};
                end
            endcase
        end
    end

    // State, storage and registered handshake flags; reset clears everything.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r <= ST_EMPTY;
            out_r   <= {PW{1'b0}};
            skid_r  <= {PW{1'b0}};
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            out_r   <= out_nxt_s;
            skid_r  <= skid_nxt_s;
            ready_r <= (state_nxt_s != ST_FULL);
            valid_r <= (state_nxt_s != ST_EMPTY);
        end
    end

    assign o_ready         = ready_r;
    assign o_valid         = valid_r;
    assign o_alu_result    = out_r[PW-1 -: NB_DATA];
    assign o_store_data    = out_r[PW-NB_DATA-1 -: NB_DATA];
    assign o_branch_target = out_r[NB_DATA+NB_REG+4 -: NB_DATA];
    assign o_rd_addr       = out_r[NB_REG+4 -: NB_REG];
    assign o_reg_write     = out_r[4];
    assign o_mem_read      = out_r[3];
    assign o_mem_write     = out_r[2];
    assign o_branch_taken  = out_r[1];
    assign o_exception     = out_r[0];

endmodule
